// File: rtl/adc_conv_scheduler_pkg.sv
// Shared definitions for the ADC conversion scheduler: state encoding,
// default parameters and the BCD range helper.
package adc_conv_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_REF  = 3'd2,
    WAIT_ZERO = 3'd3,
    LATCH     = 3'd4,
    HOLDOFF   = 3'd5
  } sched_state_t;

  localparam int TIMEOUT_DEFAULT = 4096;
  localparam int HOLD_W_DEFAULT  = 16;
  localparam int BCD_W           = 12;

  function automatic logic bcd_overrange(input logic [BCD_W-1:0] bcd);
    return (bcd[3:0] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[11:8] > 4'd9);
  endfunction

endpackage

// File: rtl/adc_conv_scheduler_timer.sv
// sched_timer: loadable down-counter with terminal-count flag, shared by the
// conversion timeout and the hold-off interval.
module sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/adc_conv_scheduler.sv
// ADC conversion scheduler: issues start pulses to the control machine, tracks
// the reference/zero phases, captures the BCD result and enforces a timeout.
//
// state     | meaning
// IDLE      | waiting for enable with continuous mode or a pending request
// START     | one-cycle adc_start pulse, timeout loaded
// WAIT_REF  | waiting for de-integration (ch_Vref) to begin
// WAIT_ZERO | waiting for ch_Vref low with ch_Zero high
// LATCH     | result presented, result_valid high
// HOLDOFF   | holdoff+1 idle cycles before the next decision
module adc_conv_scheduler
  import adc_conv_scheduler_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int HOLD_W  = HOLD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode_cont,
  input  logic              single_req,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              clear_err,
  input  logic              ch_Vref,
  input  logic              ch_Zero,
  input  logic [11:0]       count_bcd,
  output logic              adc_start,
  output logic              busy,
  output logic [11:0]       result_bcd,
  output logic              result_valid,
  output logic              overrange,
  output logic              timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int CW = (HOLD_W > TW) ? HOLD_W : TW;
  // Loading TIMEOUT-2 in START puts timeout_err up exactly TIMEOUT cycles after adc_start.
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 2);

  sched_state_t    state, state_next;
  logic            pending;
  logic            tmr_load, tmr_en, tmr_tc;
  logic [CW-1:0]   tmr_val;
  logic            latch_now, timeout_now;

  sched_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_next  = state;
    tmr_load    = 1'b0;
    tmr_val     = TO_LOAD;
    tmr_en      = 1'b0;
    latch_now   = 1'b0;
    timeout_now = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (mode_cont || pending || single_req)) state_next = START;
      end
      START: begin
        tmr_load   = 1'b1;
        state_next = WAIT_REF;
      end
      WAIT_REF: begin
        tmr_en = 1'b1;
        if (tmr_tc)       timeout_now = 1'b1;
        else if (ch_Vref) state_next  = WAIT_ZERO;
      end
      WAIT_ZERO: begin
        tmr_en = 1'b1;
        // A conversion finishing on the last allowed cycle is still accepted.
        if (!ch_Vref && ch_Zero) latch_now   = 1'b1;
        else if (tmr_tc)         timeout_now = 1'b1;
      end
      LATCH: begin
        tmr_load   = 1'b1;
        tmr_val    = CW'(holdoff);
        state_next = HOLDOFF;
      end
      HOLDOFF: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (latch_now) state_next = LATCH;
    if (timeout_now) begin
      state_next = HOLDOFF;
      tmr_load   = 1'b1;
      tmr_val    = CW'(holdoff);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      result_bcd  <= '0;
      overrange   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;

      if (state == IDLE && state_next == START) pending <= 1'b0;
      else if (single_req && enable)            pending <= 1'b1;

      // Result is sampled in the qualifying cycle so it is on the bus with result_valid.
      if (latch_now) result_bcd <= count_bcd;

      if (latch_now && bcd_overrange(count_bcd)) overrange <= 1'b1;
      else if (clear_err)                        overrange <= 1'b0;

      if (timeout_now)    timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

  assign adc_start    = (state == START);
  assign busy         = (state == START) || (state == WAIT_REF) ||
                        (state == WAIT_ZERO) || (state == LATCH);
  assign result_valid = (state == LATCH);

endmodule

// File: doc/adc_conv_scheduler.md
ADC_CONV_SCHEDULER -- requirements
Module: adc_conv_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096: max clk cycles allowed from adc_start to conversion complete.
REQ-002 SHALL have parameter HOLD_W, default 16: width of the hold-off interval.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  scheduler enable; low parks it in IDLE after any running conversion.
REQ-006 mode_cont  input  1  1 = continuous conversions, 0 = single-shot.
REQ-007 single_req  input  1  one-cycle request for one conversion (single-shot mode).
REQ-008 holdoff  input  HOLD_W  idle cycles between successive conversions in continuous mode.
REQ-009 clear_err  input  1  clears timeout_err and overrange.
REQ-010 ch_Vref  input  1  control-machine de-integration phase indicator.
REQ-011 ch_Zero  input  1  control-machine zero/discharge phase indicator.
REQ-012 count_bcd  input  12  counter BCD digits {d2,d1,d0}, 4 bits each.
REQ-013 adc_start  output  1  one-cycle start pulse to the control machine.
REQ-014 busy  output  1  high from adc_start until LATCH or timeout completes.
REQ-015 result_bcd  output  12  last captured conversion result.
REQ-016 result_valid  output  1  one-cycle pulse when result_bcd updates.
REQ-017 overrange  output  1  sticky; last captured digit > 9 seen.
REQ-018 timeout_err  output  1  sticky; conversion exceeded TIMEOUT.

Function
REQ-019 SHALL implement states IDLE, START, WAIT_REF, WAIT_ZERO, LATCH, HOLDOFF.
REQ-020 IDLE -> START when enable=1 and (mode_cont=1 or pending request set); else stay.
REQ-021 START: adc_start=1 for exactly one cycle, timeout counter cleared, -> WAIT_REF next cycle.
REQ-022 WAIT_REF -> WAIT_ZERO on first cycle ch_Vref=1.
REQ-023 WAIT_ZERO -> LATCH on first cycle ch_Vref=0 and ch_Zero=1 (end of de-integration).
REQ-024 LATCH: result_bcd <= count_bcd, result_valid=1 for one cycle, overrange set if any digit > 9, -> HOLDOFF.
REQ-025 HOLDOFF counts holdoff cycles, then -> IDLE; holdoff=0 gives exactly one HOLDOFF cycle.
REQ-026 Latency: result_valid asserts exactly 1 cycle after the ch_Vref falling-edge qualifying cycle.
REQ-027 Timeout counter runs in WAIT_REF/WAIT_ZERO; reaching TIMEOUT sets timeout_err, skips LATCH (no result_valid), -> HOLDOFF.
REQ-028 single_req while not IDLE SHALL set one pending flag (further requests coalesce); pending cleared on entering START.
REQ-029 single_req ignored when enable=0.
REQ-030 enable falling mid-conversion SHALL NOT abort; conversion completes, then IDLE holds.
REQ-031 mode_cont change takes effect only at the IDLE decision.
REQ-032 clear_err clears sticky flags; if a set event occurs same cycle, set wins.
REQ-033 busy SHALL be high in START, WAIT_REF, WAIT_ZERO, LATCH; low otherwise.

Reset
REQ-034 Asserting reset SHALL immediately force IDLE, adc_start=0, busy=0, result_bcd=0, result_valid=0, overrange=0, timeout_err=0, pending=0, all counters 0.
REQ-035 Reset mid-conversion SHALL drop the conversion without result_valid; first START after release no earlier than 1 cycle after reset deasserts.

Structure
REQ-036 State encodings and default TIMEOUT SHALL live in a shared adc package/include reused by the control machine bench.
REQ-037 Timeout and hold-off counting SHALL use one sub-module, sched_timer (load, enable, terminal-count output).

Verification
REQ-038 Single-shot: enable=1, mode_cont=0, pulse single_req; ch_Vref high 300 cycles then ch_Zero=1, count_bcd=0x123 -> one adc_start, result_bcd=0x123, one result_valid pulse.
REQ-039 Continuous: mode_cont=1, holdoff=10 -> adc_start pulses spaced (conversion length + 12) cycles, result_valid per conversion.
REQ-040 Timeout: TIMEOUT=64, ch_Vref never rises -> timeout_err=1 at cycle 64 after start, no result_valid; clear_err clears it.
REQ-041 Overrange: count_bcd=0xA05 at LATCH -> overrange=1, result_bcd=0xA05.
REQ-042 Coalescing: three single_req pulses during busy -> exactly one further conversion.
REQ-043 Reset in WAIT_ZERO -> all outputs 0 within the reset cycle, no result_valid afterward.
